// File: rtl/gf180mcu_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_clkdiv_ctrl
//  Purpose  : Programmable glitch-free integer clock divider. Z is a registered
//             divided clock that drives the clkbuf cell directly downstream.
//             Divisor changes and enable/disable only take effect on period
//             boundaries, so no runt pulse can reach the clock tree.
//  Ports    : CLK  - source clock, all state updates on rising edge
//             RN   - asynchronous active-low reset
//             EN   - 1 = run divider, 0 = stop at end of current period
//             DIV  - requested divisor (0 and 1 are treated as 2)
//             LOAD - single-cycle request to adopt DIV
//             ACK  - 1-cycle pulse, requested divisor is now active
//             BUSY - high while a load waits for the period boundary
//             Z    - divided clock output (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_clkdiv_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DIV_RST = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             ACK,
  output logic             BUSY,
  output logic             Z
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RUN   = 2'd1,
    S_PEND  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO   = WIDTH'(2);
  localparam logic [WIDTH:0]   C_ONE_X = (WIDTH+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] n_q,      n_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             z_q,      z_d;
  logic             ack_q,    ack_d;
  logic             busy_q,   busy_d;

  logic [WIDTH-1:0] div_sat;
  logic [WIDTH:0]   half;
  logic             wrap;
  logic [WIDTH-1:0] cnt_nxt;
  logic             z_cnt;

  // Divisors below 2 cannot form a high and a low phase; clamp them.
  assign div_sat = (DIV < C_TWO) ? C_TWO : DIV;

  // H = ceil(N/2), one bit wider so N at full scale cannot overflow.
  assign half    = ({1'b0, n_q} + C_ONE_X) >> 1;
  assign wrap    = (cnt_q == (n_q - C_ONE));
  assign cnt_nxt = wrap ? '0 : (cnt_q + C_ONE);
  // Z is derived from the next count so the output register is aligned with
  // the counter: Z=1 exactly in the cycles where CNT < H.
  assign z_cnt   = ({1'b0, cnt_nxt} < half);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      n_q      <= WIDTH'(DIV_RST);
      shadow_q <= WIDTH'(DIV_RST);
      z_q      <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      shadow_q <= shadow_d;
      z_q      <= z_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    shadow_d = shadow_q;
    z_d      = z_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        z_d   = 1'b0;
        if (LOAD) begin
          n_d   = div_sat;
          ack_d = 1'b1;
        end
        if (EN) begin
          // First period starts right away: CNT=0 with Z high.
          state_d = S_RUN;
          z_d     = 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = cnt_nxt;
        z_d   = z_cnt;
        if (LOAD) begin
          if (wrap) begin
            // Already at the boundary: switch now, new period begins with ACK.
            n_d     = div_sat;
            ack_d   = 1'b1;
            state_d = EN ? S_RUN : S_DRAIN;
          end else begin
            shadow_d = div_sat;
            busy_d   = 1'b1;
            state_d  = S_PEND;
          end
        end else if (!EN) begin
          if (wrap) begin
            // Current period ends on this edge; stop here instead of
            // starting another one just to drain it.
            state_d = S_OFF;
            z_d     = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_PEND: begin
        // LOAD is ignored here; the shadow is applied at the next boundary
        // whether or not EN is still high.
        cnt_d = cnt_nxt;
        z_d   = z_cnt;
        if (wrap) begin
          n_d     = shadow_q;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = EN ? S_RUN : S_DRAIN;
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_nxt;
        z_d   = z_cnt;
        if (LOAD && !wrap) begin
          shadow_d = div_sat;
          busy_d   = 1'b1;
          state_d  = S_PEND;
        end else if (wrap) begin
          z_d     = 1'b0;
          state_d = S_OFF;
          if (LOAD) begin
            n_d   = div_sat;
            ack_d = 1'b1;
          end
        end else if (EN) begin
          // Re-enabled mid-period: keep counting, Z is undisturbed.
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        z_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign Z    = z_q;

endmodule
`default_nettype wire
